// File: rtl/eks_blowfish_setup.sv
// Iterative simplified bcrypt core: EksBlowfishSetup over an 18-word P-array with an
// arithmetic F function, followed by ciphertext generation. Emits {cost, salt, ctext}.
module eks_blowfish_setup (
  input  logic         clk,
  input  logic [127:0] Salt,
  input  logic [7:0]   cost,
  input  logic [575:0] Key,
  input  logic         rst,
  output logic [327:0] cryptm
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_INIT,
    S_LOOP,
    S_CTEXT,
    S_DONE
  } state_t;

  localparam logic [31:0] PI_INIT [18] = '{
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822, 32'h299F31D0,
    32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917, 32'h9216D5D9, 32'h8979FB1B
  };

  localparam logic [4:0] LAST_ROUND = 5'd16;

  function automatic logic [31:0] f_mix(input logic [31:0] x);
    return ({x[24:0], x[31:25]} + {x[12:0], x[31:13]}) ^ 32'h9E3779B9;
  endfunction

  // Plaintext block encrypted 64 times during ciphertext generation.
  function automatic logic [63:0] ctext_block(input logic [1:0] idx);
    case (idx)
      2'd0:    return {32'h4F727068, 32'h65616E42};
      2'd1:    return {32'h65686F6C, 32'h64657253};
      default: return {32'h63727944, 32'h6F756274};
    endcase
  endfunction

  state_t         state_q;
  logic [31:0]    p_q [18];
  logic [575:0]   key_q;
  logic [127:0]   salt_q;
  logic [7:0]     cost_q;
  logic [31:0]    l_q, r_q;
  logic [4:0]     round_q;
  logic [3:0]     blk_q;
  logic           kx_q;      // next expand cycle is the parallel key-XOR cycle
  logic           half_q;    // 0: expand with Key, 1: expand with salt repeated
  logic [31:0]    iter_q;
  logic [5:0]     enc_q;
  logic [1:0]     cblk_q;
  logic [191:0]   ctext_q;
  logic [327:0]   cryptm_q;

  logic [31:0]    kw [18];
  logic [31:0]    iter_last;
  logic           d_en;
  logic [63:0]    d_word;
  logic [31:0]    l_in, r_in, t_mix, rnd_l, rnd_r, fin_l, fin_r;
  logic [4:0]     p_idx_lo, p_idx_hi;

  assign iter_last = (32'd1 << cost_q[4:0]) - 32'd1;
  assign d_en      = (state_q == S_INIT) && !kx_q && (round_q == 5'd0);
  assign d_word    = blk_q[0] ? salt_q[63:0] : salt_q[127:64];
  assign p_idx_lo  = {blk_q, 1'b0};
  assign p_idx_hi  = {blk_q, 1'b1};
  assign fin_l     = r_q ^ p_q[17];
  assign fin_r     = l_q ^ p_q[16];
  assign cryptm    = cryptm_q;

  always_comb begin
    for (int i = 0; i < 18; i++) begin
      kw[i] = half_q ? salt_q[127 - 32 * (i % 4) -: 32] : key_q[575 - 32 * i -: 32];
    end
  end

  // One Feistel round; salt half is folded in on the first round of each INIT block.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    l_in = l_q;
    r_in = r_q;
    if (d_en) begin
      l_in = l_q ^ d_word[63:32];
      r_in = r_q ^ d_word[31:0];
    end
    t_mix = l_in ^ p_q[round_q[3:0]];
    rnd_l = r_in ^ f_mix(t_mix);
    rnd_r = t_mix;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
      // NOTE: the P-array is architectural state with defined initial contents, so it is reset.
      for (int i = 0; i < 18; i++) p_q[i] <= PI_INIT[i];
      key_q    <= '0;
      salt_q   <= '0;
      cost_q   <= '0;
      l_q      <= '0;
      r_q      <= '0;
      round_q  <= '0;
      blk_q    <= '0;
      kx_q     <= 1'b0;
      half_q   <= 1'b0;
      iter_q   <= '0;
      enc_q    <= '0;
      cblk_q   <= '0;
      ctext_q  <= '0;
      cryptm_q <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          key_q   <= Key;
          salt_q  <= Salt;
          cost_q  <= cost;
          kx_q    <= 1'b1;
          half_q  <= 1'b0;
          iter_q  <= '0;
          round_q <= '0;
          blk_q   <= '0;
          state_q <= S_INIT;
        end

        S_INIT, S_LOOP: begin
          if (kx_q) begin
            for (int i = 0; i < 18; i++) p_q[i] <= p_q[i] ^ kw[i];
            l_q     <= '0;
            r_q     <= '0;
            kx_q    <= 1'b0;
            round_q <= '0;
            blk_q   <= '0;
          end else if (round_q != LAST_ROUND) begin
            l_q     <= rnd_l;
            r_q     <= rnd_r;
            round_q <= round_q + 5'd1;
          end else begin
            p_q[p_idx_lo] <= fin_l;
            p_q[p_idx_hi] <= fin_r;
            l_q           <= fin_l;
            r_q           <= fin_r;
            round_q       <= '0;
            if (blk_q != 4'd8) begin
              blk_q <= blk_q + 4'd1;
            end else begin
              blk_q <= '0;
              kx_q  <= 1'b1;
              if (state_q == S_INIT) begin
                state_q <= S_LOOP;
              end else if (!half_q) begin
                half_q <= 1'b1;
              end else begin
                half_q <= 1'b0;
                if (iter_q == iter_last) begin
                  kx_q       <= 1'b0;
                  enc_q      <= '0;
                  cblk_q     <= '0;
                  {l_q, r_q} <= ctext_block(2'd0);
                  state_q    <= S_CTEXT;
                end else begin
                  iter_q <= iter_q + 32'd1;
                end
              end
            end
          end
        end

        S_CTEXT: begin
          if (round_q != LAST_ROUND) begin
            l_q     <= rnd_l;
            r_q     <= rnd_r;
            round_q <= round_q + 5'd1;
          end else begin
            round_q <= '0;
            if (enc_q != 6'd63) begin
              enc_q <= enc_q + 6'd1;
              l_q   <= fin_l;
              r_q   <= fin_r;
            end else begin
              enc_q   <= '0;
              ctext_q <= {ctext_q[127:0], fin_l, fin_r};
              if (cblk_q != 2'd2) begin
                cblk_q     <= cblk_q + 2'd1;
                {l_q, r_q} <= ctext_block(cblk_q + 2'd1);
              end else begin
                cryptm_q <= {cost_q, salt_q, ctext_q[127:0], fin_l, fin_r};
                state_q  <= S_DONE;
              end
            end
          end
        end

        S_DONE: begin
          state_q <= S_DONE;
        end

        default: state_q <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_eks_blowfish_setup.sv
// Scoreboard bench for eks_blowfish_setup: a behavioural bcrypt model fills the queue,
// a monitor compares each completed hash and the edge on which it appeared.
module tb_eks_blowfish_setup;

  logic         clk;
  logic         rst;
  logic [127:0] Salt;
  logic [7:0]   cost;
  logic [575:0] Key;
  logic [327:0] cryptm;

  eks_blowfish_setup dut (
    .clk    (clk),
    .Salt   (Salt),
    .cost   (cost),
    .Key    (Key),
    .rst    (rst),
    .cryptm (cryptm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [575:0] PI_VEC = {
    32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822, 32'h299F31D0,
    32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
    32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917, 32'h9216D5D9, 32'h8979FB1B
  };
  localparam logic [191:0] CBLK_VEC = {
    32'h4F727068, 32'h65616E42, 32'h65686F6C, 32'h64657253, 32'h63727944, 32'h6F756274
  };

  typedef struct {
    logic [327:0] val;
    int           edge_n;
  } exp_t;

  exp_t         sb_q [$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_errors = 0;
  int           done_cnt = 0;
  int           edge_cnt;
  bit           prev_zero = 1'b1;
  logic [191:0] last_ctext = '0;
  logic [31:0]  mp [18];

  task automatic check(input bit ok, input string name, input logic [327:0] act,
                       input logic [327:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] mf(input logic [31:0] x);
    logic [31:0] a, b;
    a = (x << 7) | (x >> 25);
    b = (x >> 13) | (x << 19);
    return (a + b) ^ 32'h9E3779B9;
  endfunction

  task automatic m_encrypt(inout logic [31:0] l, inout logic [31:0] r);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      l = l ^ mp[i];
      r = r ^ mf(l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ mp[16];
    l = l ^ mp[17];
  endtask

  task automatic m_expand(input logic [575:0] k, input bit use_d, input logic [127:0] s);
    logic [31:0] l, r;
    for (int i = 0; i < 18; i++) mp[i] = mp[i] ^ k[575 - 32 * i -: 32];
    l = '0;
    r = '0;
    for (int blk = 0; blk < 9; blk++) begin
      if (use_d) begin
        if (blk % 2 == 0) begin
          l = l ^ s[127:96];
          r = r ^ s[95:64];
        end else begin
          l = l ^ s[63:32];
          r = r ^ s[31:0];
        end
      end
      m_encrypt(l, r);
      mp[2 * blk]     = l;
      mp[2 * blk + 1] = r;
    end
  endtask

  task automatic model_hash(input logic [575:0] k, input logic [127:0] s, input logic [7:0] c,
                            output logic [327:0] h);
    logic [575:0] pi_v, rep;
    logic [191:0] blocks, ct;
    logic [31:0]  l, r;
    pi_v = PI_VEC;
    for (int i = 0; i < 18; i++) mp[i] = pi_v[575 - 32 * i -: 32];
    rep = {s, s, s, s, s[127:64]};
    m_expand(k, 1'b1, s);
    for (int it = 0; it < (1 << c[4:0]); it++) begin
      m_expand(k, 1'b0, s);
      m_expand(rep, 1'b0, s);
    end
    blocks = CBLK_VEC;
    for (int b = 0; b < 3; b++) begin
      l = blocks[191 - 64 * b -: 32];
      r = blocks[159 - 64 * b -: 32];
      for (int e = 0; e < 64; e++) m_encrypt(l, r);
      ct[191 - 64 * b -: 64] = {l, r};
    end
    h = {c, s, ct};
  endtask

  // ---------------- edge counter and monitor ----------------
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_zero = 1'b1;
    end else begin
      if (cryptm != '0 && prev_zero) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_output", cryptm, 328'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check(cryptm == mon_e.val, "hash_value", cryptm, mon_e.val);
          check(edge_cnt == mon_e.edge_n, "done_edge", 328'(edge_cnt), 328'(mon_e.edge_n));
          last_ctext = cryptm[191:0];
          done_cnt++;
        end
      end
      prev_zero = (cryptm == '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input int target, input int limit);
    int n;
    n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(done_cnt >= target, "completion_timeout", 328'(done_cnt), 328'(target));
  endtask

  task automatic start_run(input logic [575:0] k, input logic [127:0] s, input logic [7:0] c,
                           input int n_edge, input bit expect_done, output logic [327:0] h);
    exp_t e;
    @(negedge clk);
    Key  = k;
    Salt = s;
    cost = c;
    model_hash(k, s, c, h);
    if (expect_done) begin
      e.val    = h;
      e.edge_n = n_edge;
      sb_q.push_back(e);
    end
    rst = 1'b1;
  endtask

  logic [575:0] key13;
  logic [127:0] salt32;
  logic [327:0] exp_a, exp_b, exp_tmp;
  logic [191:0] ctext_a;

  initial begin
    key13  = 576'd13;
    salt32 = 128'd32;
    rst    = 1'b0;
    Key    = {18{32'hA5A5_0F0F}};
    Salt   = {4{32'h1234_5678}};
    cost   = 8'hFF;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Key[31:0] = $urandom;
      check(cryptm == '0, "reset_zero", cryptm, 328'd0);
    end

    // Run A: cost=1 reference run
    start_run(key13, salt32, 8'd1, 4035, 1'b1, exp_a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check(cryptm == '0, "post_release_zero", cryptm, 328'd0);
    end
    wait_done(1, 4100);
    check(cryptm[327:320] == 8'd1, "cost_field", 328'(cryptm[327:320]), 328'd1);
    check(cryptm[319:192] == 128'd32, "salt_field", 328'(cryptm[319:192]), 328'd32);
    ctext_a = last_ctext;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check(cryptm == exp_a, "hold_after_done", cryptm, exp_a);
    end
    #2 rst = 1'b0;
    #1 check(cryptm == '0, "async_clear", cryptm, 328'd0);

    // Run B: cost=0 completes earlier with a different ciphertext
    start_run(key13, salt32, 8'd0, 3727, 1'b1, exp_b);
    wait_done(2, 3800);
    check(last_ctext != ctext_a, "cost_ctext_differs", 328'(last_ctext), 328'(ctext_a));
    @(negedge clk);
    rst = 1'b0;

    // Run C: inputs disturbed after the LOAD edge must be ignored
    start_run(key13, salt32, 8'd1, 4035, 1'b1, exp_tmp);
    @(negedge clk);
    Key  = {18{32'hDEAD_BEEF}};
    Salt = 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
    cost = 8'h03;
    wait_done(3, 4100);
    check(last_ctext == exp_a[191:0], "latched_inputs", 328'(last_ctext), 328'(exp_a[191:0]));
    @(negedge clk);
    rst = 1'b0;

    // Run D: abort mid-LOOP, then a clean rerun
    start_run(key13, salt32, 8'd1, 4035, 1'b0, exp_tmp);
    repeat (500) @(negedge clk);
    check(edge_cnt == 500, "abort_point", 328'(edge_cnt), 328'd500);
    rst = 1'b0;
    #1 check(cryptm == '0, "abort_zero", cryptm, 328'd0);
    repeat (3) @(negedge clk);
    start_run(key13, salt32, 8'd1, 4035, 1'b1, exp_tmp);
    wait_done(4, 4100);
    check(last_ctext == exp_a[191:0], "rerun_ctext", 328'(last_ctext), 328'(exp_a[191:0]));

    @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", 328'(sb_q.size()), 328'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
